// File: rtl/lac_pkg.sv
// Shared encodings for the 40 MHz phase-strobe logic in the clock4x domain.
// Used by the strobe generator, the strobe monitor and downstream fast-domain consumers.
package lac_pkg;

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_ACQUIRE  = 2'd1;
    localparam logic [1:0] ST_LOCKED   = 2'd2;

    // Sub-BX phase on which the next strobe is due
    localparam logic [1:0] PHASE_LAST  = 2'd3;

    typedef enum logic [1:0] {
        S_UNLOCKED = ST_UNLOCKED,
        S_ACQUIRE  = ST_ACQUIRE,
        S_LOCKED   = ST_LOCKED
    } lac_state_e;

endpackage

// File: rtl/lac_strobe_monitor_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {WIDTH{1'b1}}))
            cnt_d = cnt_q + WIDTH'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/lac_strobe_monitor.sv
// Checks the 1-in-4 phase strobe in the clock4x domain, acquires/holds lock and publishes the sub-BX phase.
// Optional error counter built only when LAC_STROBE_MON_ERRCNT_EN is defined; otherwise err_cnt is tied to 0.
module lac_strobe_monitor
    import lac_pkg::*;
#(
    parameter int LOCK_COUNT  = 8,
    parameter int UNLOCK_ERRS = 2,
    parameter int ERR_W       = 16
) (
    input  logic             clock4x,
    input  logic             reset,
    input  logic             strobe4x,
    output logic [1:0]       phase,
    output logic             locked,
    output logic             lock_lost,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [3:0] LOCK_CNT   = 4'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_CNT = 4'(UNLOCK_ERRS);

    lac_state_e state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic [3:0] good_cnt_q, good_cnt_d;
    logic [3:0] bad_cnt_q, bad_cnt_d;
    logic       locked_q;
    logic       lock_lost_q, lock_lost_d;

    logic good, spurious, missing, bad;

    assign good     =  strobe4x & (phase_q == PHASE_LAST);
    assign spurious =  strobe4x & (phase_q != PHASE_LAST);
    assign missing  = ~strobe4x & (phase_q == PHASE_LAST);
    assign bad      =  spurious | missing;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q + 2'd1;
        good_cnt_d  = good_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        lock_lost_d = 1'b0;
        case (state_q)
            S_UNLOCKED: begin
                if (strobe4x) begin
                    phase_d    = 2'd0;
                    good_cnt_d = 4'd1;
                    state_d    = S_ACQUIRE;
                end
            end
            S_ACQUIRE: begin
                if (good) begin
                    good_cnt_d = good_cnt_q + 4'd1;
                    if (good_cnt_q + 4'd1 == LOCK_CNT) state_d = S_LOCKED;
                end else if (spurious) begin
                    phase_d    = 2'd0;
                    good_cnt_d = 4'd1;
                end else if (missing) begin
                    good_cnt_d = 4'd0;
                    state_d    = S_UNLOCKED;
                end
            end
            S_LOCKED: begin
                // Once locked the phase free-runs; bad events only count towards unlock
                if (good) begin
                    bad_cnt_d = 4'd0;
                end else if (bad) begin
                    if (bad_cnt_q + 4'd1 == UNLOCK_CNT) begin
                        state_d     = S_UNLOCKED;
                        lock_lost_d = 1'b1;
                        bad_cnt_d   = 4'd0;
                        good_cnt_d  = 4'd0;
                    end else begin
                        bad_cnt_d = bad_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = S_UNLOCKED;
        endcase
    end

    always_ff @(posedge clock4x) begin
        if (reset) begin
            state_q     <= S_UNLOCKED;
            phase_q     <= 2'd0;
            good_cnt_q  <= 4'd0;
            bad_cnt_q   <= 4'd0;
            locked_q    <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            locked_q    <= (state_d == S_LOCKED);
            lock_lost_q <= lock_lost_d;
        end
    end

    assign phase     = phase_q;
    assign locked    = locked_q;
    assign lock_lost = lock_lost_q;

`ifdef LAC_STROBE_MON_ERRCNT_EN
    logic err_inc;
    assign err_inc = (state_q == S_LOCKED) & bad;

    sat_counter #(.WIDTH(ERR_W)) u_err_cnt (
        .clk_i (clock4x),
        .rst_i (reset),
        .inc_i (err_inc),
        .cnt_o (err_cnt)
    );
`else
    assign err_cnt = '0;
`endif

endmodule
